arm_iter_mac: RTL and testbench

Parametrised iterative multiply-accumulate unit for the execute stage. It replaces the single-cycle 32-bit MAC and adds 64-bit long multiplies (UMULL/UMLAL/SMULL/SMLAL). The datapath width and the number of multiplier bits retired per cycle are configurable. The unit sits beside the ALU in EX, uses a valid/ready handshake on both sides so the pipeline can stall on it, and supports a flush that kills the in-flight operation.

---
 rtl/arm_mac_pkg.sv | 40 ++++
 rtl/arm_iter_mac_step.sv | 32 +++
 rtl/arm_iter_mac.sv | 167 ++++++++++++++++
 tb/tb_arm_iter_mac.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arm_mac_pkg
// Description : Opcode, state and opcode-bit definitions for arm_iter_mac.
// Revision    : 1.0 - initial release
// ============================================================================
package arm_mac_pkg;

    typedef enum logic [2:0] {
        MAC_MUL   = 3'd0,
        MAC_MLA   = 3'd1,
        MAC_UMULL = 3'd4,
        MAC_UMLAL = 3'd5,
        MAC_SMULL = 3'd6,
        MAC_SMLAL = 3'd7
    } mac_op_t;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_ACC  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = c_ST_IDLE,
        BUSY = c_ST_BUSY,
        ACC  = c_ST_ACC,
        DONE = c_ST_DONE
    } mac_state_t;

    localparam int c_OP_BIT_ACC    = 0;
    localparam int c_OP_BIT_SIGNED = 1;
    localparam int c_OP_BIT_LONG   = 2;

    // Signedness only has meaning for the long forms.
    function automatic logic op_is_signed(input mac_op_t op);
        return op[c_OP_BIT_LONG] & op[c_OP_BIT_SIGNED];
    endfunction

endpackage : arm_mac_pkg
`default_nettype wire

// File: rtl/arm_iter_mac_step.sv
`default_nettype none
// ============================================================================
// Module      : arm_iter_mac_step
// Description : One radix-2^BITS_PER_CYCLE partial-product accumulation step.
// Revision    : 1.0 - initial release
// ============================================================================
module arm_iter_mac_step #(
    parameter int DATA_W         = 32,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic [2*DATA_W-1:0]       i_partial,
    input  logic [2*DATA_W-1:0]       i_mcand,
    input  logic [BITS_PER_CYCLE-1:0] i_group,
    output logic [2*DATA_W-1:0]       o_next
);

    logic [2*DATA_W-1:0] w_sum;

    // The multiplicand arrives pre-aligned to the group's weight.
    always_comb begin
        w_sum = i_partial;
        for (int b = 0; b < BITS_PER_CYCLE; b++) begin
            if (i_group[b]) begin
                w_sum = w_sum + (i_mcand << b);
            end
        end
    end

    assign o_next = w_sum;

endmodule : arm_iter_mac_step
`default_nettype wire

// File: rtl/arm_iter_mac.sv
`default_nettype none
// ============================================================================
// Module      : arm_iter_mac
// Description : Iterative 32/64-bit multiply-accumulate unit with handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module arm_iter_mac
    import arm_mac_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int BITS_PER_CYCLE = 4,
    parameter int TAG_W          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  mac_op_t           in_op,
    input  logic              in_set_flags,
    input  logic [DATA_W-1:0] in_rm,
    input  logic [DATA_W-1:0] in_rs,
    input  logic [DATA_W-1:0] in_acc_lo,
    input  logic [DATA_W-1:0] in_acc_hi,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_lo,
    output logic [DATA_W-1:0] out_hi,
    output logic              out_long,
    output logic [3:0]        out_flags,
    output logic              out_flags_we,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);

    localparam int                 c_ITERS    = DATA_W / BITS_PER_CYCLE;
    localparam int                 c_CNT_W    = (c_ITERS > 1) ? $clog2(c_ITERS) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_ITERS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam int                 c_PROD_W   = 2 * DATA_W;

    mac_state_t            r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_PROD_W-1:0]   r_mcand;
    logic [c_PROD_W-1:0]   r_partial;
    logic [c_PROD_W-1:0]   r_acc;
    logic [DATA_W-1:0]     r_mplier;
    logic                  r_neg;
    logic                  r_long;
    logic                  r_set_flags;
    logic [TAG_W-1:0]      r_tag;

    logic                  w_accept;
    logic                  w_signed;
    logic [DATA_W-1:0]     w_rm_mag;
    logic [DATA_W-1:0]     w_rs_mag;
    logic [c_PROD_W-1:0]   w_acc_in;
    logic [c_PROD_W-1:0]   w_step_next;
    logic [c_PROD_W-1:0]   w_prod;
    logic [c_PROD_W-1:0]   w_result;
    logic                  w_res_n;
    logic                  w_res_z;

    assign in_ready = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign w_accept = in_valid && in_ready && !flush;
    assign busy     = (r_state != IDLE);

    // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
    assign w_signed = op_is_signed(in_op);
    assign w_rm_mag = (w_signed && in_rm[DATA_W-1]) ? -in_rm : in_rm;
    assign w_rs_mag = (w_signed && in_rs[DATA_W-1]) ? -in_rs : in_rs;

    assign w_acc_in = !in_op[c_OP_BIT_ACC]  ? '0 :
                      in_op[c_OP_BIT_LONG]  ? {in_acc_hi, in_acc_lo} :
                                              {{DATA_W{1'b0}}, in_acc_lo};

    arm_iter_mac_step #(
        .DATA_W         (DATA_W),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .i_partial (r_partial),
        .i_mcand   (r_mcand),
        .i_group   (r_mplier[BITS_PER_CYCLE-1:0]),
        .o_next    (w_step_next)
    );

    assign w_prod   = r_neg ? -r_partial : r_partial;
    assign w_result = w_prod + r_acc;
    assign w_res_n  = r_long ? w_result[c_PROD_W-1] : w_result[DATA_W-1];
    assign w_res_z  = r_long ? (w_result == '0) : (w_result[DATA_W-1:0] == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_mcand      <= '0;
            r_partial    <= '0;
            r_acc        <= '0;
            r_mplier     <= '0;
            r_neg        <= 1'b0;
            r_long       <= 1'b0;
            r_set_flags  <= 1'b0;
            r_tag        <= '0;
            out_valid    <= 1'b0;
            out_lo       <= '0;
            out_hi       <= '0;
            out_long     <= 1'b0;
            out_flags    <= 4'b0000;
            out_flags_we <= 1'b0;
            out_tag      <= '0;
        end else if (flush) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    r_partial <= w_step_next;
                    r_mcand   <= r_mcand << BITS_PER_CYCLE;
                    r_mplier  <= r_mplier >> BITS_PER_CYCLE;
                    r_cnt     <= r_cnt + c_CNT_ONE;
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= ACC;
                    end
                end
                ACC: begin
                    out_lo       <= w_result[DATA_W-1:0];
                    out_hi       <= r_long ? w_result[c_PROD_W-1:DATA_W] : '0;
                    out_long     <= r_long;
                    out_flags    <= {w_res_n, w_res_z, 2'b00};
                    out_flags_we <= r_set_flags;
                    out_tag      <= r_tag;
                    out_valid    <= 1'b1;
                    r_state      <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= w_accept ? BUSY : IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Acceptance only happens in IDLE or DONE, so this never collides with BUSY updates.
            if (w_accept) begin
                r_cnt       <= '0;
                r_mcand     <= {{DATA_W{1'b0}}, w_rm_mag};
                r_mplier    <= w_rs_mag;
                r_partial   <= '0;
                r_acc       <= w_acc_in;
                r_neg       <= w_signed && (in_rm[DATA_W-1] ^ in_rs[DATA_W-1]);
                r_long      <= in_op[c_OP_BIT_LONG];
                r_set_flags <= in_set_flags;
                r_tag       <= in_tag;
            end
        end
    end

endmodule : arm_iter_mac
`default_nettype wire

// File: tb/tb_arm_iter_mac.sv
`default_nettype none
// ============================================================================
// Module      : tb_arm_iter_mac
// Description : Directed self-checking bench for arm_iter_mac (radix 16 and 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arm_iter_mac;
    import arm_mac_pkg::*;

    localparam int W  = 32;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_set_flags, out_ready;
    mac_op_t       in_op;
    logic [W-1:0]  in_rm, in_rs, in_acc_lo, in_acc_hi;
    logic [TW-1:0] in_tag;

    logic          in_ready, out_valid, out_long, out_flags_we, busy;
    logic [W-1:0]  out_lo, out_hi;
    logic [3:0]    out_flags;
    logic [TW-1:0] out_tag;

    logic          in_ready_1, out_valid_1, out_long_1, out_flags_we_1, busy_1;
    logic [W-1:0]  out_lo_1, out_hi_1;
    logic [3:0]    out_flags_1;
    logic [TW-1:0] out_tag_1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    arm_iter_mac #(.DATA_W(W), .BITS_PER_CYCLE(4), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_set_flags(in_set_flags), .in_rm(in_rm), .in_rs(in_rs),
        .in_acc_lo(in_acc_lo), .in_acc_hi(in_acc_hi), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_lo(out_lo), .out_hi(out_hi),
        .out_long(out_long), .out_flags(out_flags), .out_flags_we(out_flags_we),
        .out_tag(out_tag), .busy(busy)
    );

    arm_iter_mac #(.DATA_W(W), .BITS_PER_CYCLE(1), .TAG_W(TW)) dut_1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_1),
        .in_op(in_op), .in_set_flags(in_set_flags), .in_rm(in_rm), .in_rs(in_rs),
        .in_acc_lo(in_acc_lo), .in_acc_hi(in_acc_hi), .in_tag(in_tag),
        .out_valid(out_valid_1), .out_ready(out_ready), .out_lo(out_lo_1), .out_hi(out_hi_1),
        .out_long(out_long_1), .out_flags(out_flags_1), .out_flags_we(out_flags_we_1),
        .out_tag(out_tag_1), .busy(busy_1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input mac_op_t op, input logic s, input logic [W-1:0] rm,
                         input logic [W-1:0] rs, input logic [W-1:0] alo,
                         input logic [W-1:0] ahi, input logic [TW-1:0] tag);
        chk("issue_ready", in_ready, 1);
        in_valid = 1'b1; in_op = op; in_set_flags = s; in_rm = rm; in_rs = rs;
        in_acc_lo = alo; in_acc_hi = ahi; in_tag = tag;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic check_res(input string tag, input logic [W-1:0] lo, input logic [W-1:0] hi,
                             input logic lng, input logic [3:0] fl, input logic we,
                             input logic [TW-1:0] t);
        chk({tag, "_lo"}, out_lo, lo);
        chk({tag, "_hi"}, out_hi, hi);
        chk({tag, "_long"}, out_long, lng);
        chk({tag, "_flags"}, out_flags, fl);
        chk({tag, "_fwe"}, out_flags_we, we);
        chk({tag, "_tag"}, out_tag, t);
    endtask

    task automatic run_op(input string tag, input mac_op_t op, input logic s,
                          input logic [W-1:0] rm, input logic [W-1:0] rs,
                          input logic [W-1:0] alo, input logic [W-1:0] ahi,
                          input logic [TW-1:0] t, input logic [W-1:0] lo,
                          input logic [W-1:0] hi, input logic lng, input logic [3:0] fl);
        int n;
        issue(op, s, rm, rs, alo, ahi, t);
        wait_valid(n);
        chk({tag, "_latency"}, n, 9);
        check_res(tag, lo, hi, lng, fl, s, t);
        step();
        chk({tag, "_valid_drop"}, out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n;
        logic seen;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = MAC_MUL; in_set_flags = 1'b0;
        in_rm = '0; in_rs = '0; in_acc_lo = '0; in_acc_hi = '0; in_tag = '0; out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 1);
        check_res("rst", 32'h0, 32'h0, 1'b0, 4'b0000, 1'b0, 8'h00);

        run_op("mul",    MAC_MUL,   1'b1, 32'd7,        32'd6,        32'd0, 32'd0, 8'h21,
               32'd42,        32'h0,        1'b0, 4'b0000);
        run_op("mla",    MAC_MLA,   1'b1, 32'hFFFFFFFF, 32'd1,        32'd1, 32'd0, 8'h32,
               32'h0,         32'h0,        1'b0, 4'b0100);
        run_op("smull",  MAC_SMULL, 1'b1, 32'hFFFFFFFE, 32'd3,        32'd0, 32'd0, 8'h43,
               32'hFFFFFFFA,  32'hFFFFFFFF, 1'b1, 4'b1000);
        run_op("umlal",  MAC_UMLAL, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 8'h54,
               32'h00000002,  32'hFFFFFFFE, 1'b1, 4'b1000);
        run_op("smin",   MAC_SMULL, 1'b1, 32'h80000000, 32'h80000000, 32'd0, 32'd0, 8'h65,
               32'h0,         32'h40000000, 1'b1, 4'b0000);
        run_op("umull",  MAC_UMULL, 1'b0, 32'h80000000, 32'd2,        32'd0, 32'd0, 8'h76,
               32'h0,         32'h1,        1'b1, 4'b0000);
        run_op("smlal",  MAC_SMLAL, 1'b1, 32'hFFFFFFFF, 32'd5,        32'd5, 32'd0, 8'h87,
               32'h0,         32'h0,        1'b1, 4'b0100);

        // Back-pressure: result must hold while the consumer stalls.
        out_ready = 1'b0;
        issue(MAC_MUL, 1'b1, 32'd3, 32'd5, 32'd0, 32'd0, 8'h55);
        wait_valid(n);
        chk("bp_latency", n, 9);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_lo", out_lo, 32'd15);
            chk("bp_tag", out_tag, 8'h55);
            chk("bp_ready", in_ready, 0);
            step();
        end
        in_valid = 1'b1; in_op = MAC_MUL; in_set_flags = 1'b0; in_rm = 32'd10; in_rs = 32'd10;
        in_acc_lo = '0; in_acc_hi = '0; in_tag = 8'h66; out_ready = 1'b1;
        #1;
        chk("bp_ready_release", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("bp_valid_drop", out_valid, 0);
        chk("bp_busy", busy, 1);
        wait_valid(n);
        chk("bp2_latency", n, 9);
        check_res("bp2", 32'd100, 32'h0, 1'b0, 4'b0000, 1'b0, 8'h66);
        step();

        // Flush in the third BUSY cycle.
        issue(MAC_MUL, 1'b1, 32'd11, 32'd11, 32'd0, 32'd0, 8'h77);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            seen = seen | out_valid;
            step();
        end
        chk("flush_busy_novalid", seen, 0);

        // Flush together with in_valid in IDLE: nothing is accepted.
        in_valid = 1'b1; in_op = MAC_MUL; in_rm = 32'd2; in_rs = 32'd2; in_tag = 8'h88;
        flush = 1'b1;
        step();
        in_valid = 1'b0;
        flush = 1'b0;
        chk("flush_idle_busy", busy, 0);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            seen = seen | out_valid;
            step();
        end
        chk("flush_idle_novalid", seen, 0);

        run_op("post_flush", MAC_MUL, 1'b0, 32'd9, 32'd9, 32'd0, 32'd0, 8'h99,
               32'd81, 32'h0, 1'b0, 4'b0000);

        // Reset in the middle of BUSY clears everything.
        issue(MAC_UMULL, 1'b1, 32'hFFFFFFFF, 32'd7, 32'd0, 32'd0, 8'hAA);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_ready", in_ready, 1);
        check_res("mrst", 32'h0, 32'h0, 1'b0, 4'b0000, 1'b0, 8'h00);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            seen = seen | out_valid;
            step();
        end
        chk("mrst_novalid", seen, 0);

        // One multiplier bit per cycle.
        n = 0;
        while (busy_1 !== 1'b0 && n < 100) begin
            step();
            n++;
        end
        chk("bpc1_idle", busy_1, 0);
        chk("bpc1_ready", in_ready_1, 1);
        issue(MAC_MUL, 1'b1, 32'd7, 32'd6, 32'd0, 32'd0, 8'h21);
        n = 0;
        while (out_valid_1 !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk("bpc1_latency", n, 33);
        chk("bpc1_lo", out_lo_1, 32'd42);
        chk("bpc1_hi", out_hi_1, 32'h0);
        chk("bpc1_flags", out_flags_1, 4'b0000);
        chk("bpc1_tag", out_tag_1, 8'h21);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_arm_iter_mac
`default_nettype wire
